unit_dispatcher: RTL and testbench

Queues start requests from the game/control logic and hands each one to a free worker unit out of a pool of N identical units, tracking which units are busy until they report done. Units are chosen round-robin, so work is spread evenly across the pool. The block sits between the request source and the N unit `start` inputs, and it replaces direct fan-out of a single start pulse. An optional per-unit watchdog reclaims units that never report done.

---
 rtl/unit_dispatcher_if.sv | 28 ++
 rtl/unit_dispatcher.sv | 126 ++++++++++++
 tb/tb_unit_dispatcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/unit_dispatcher_if.sv
// Request/done/start bundle between the request source, the worker pool and unit_dispatcher.
interface unit_dispatcher_if #(
  parameter int unsigned N      = 13,
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned PW = $clog2(QDEPTH + 1);

  logic          en;
  logic          req;
  logic [N-1:0]  done;
  logic [N-1:0]  start_out;
  logic [N-1:0]  busy;
  logic [PW-1:0] pending;
  logic          queue_full;
  logic          overflow;
  logic          idle;
  logic [N-1:0]  timeout_err;

  modport master (
    output en, req, done,
    input  start_out, busy, pending, queue_full, overflow, idle, timeout_err
  );

  modport slave (
    input  en, req, done,
    output start_out, busy, pending, queue_full, overflow, idle, timeout_err
  );
endinterface

// File: rtl/unit_dispatcher.sv
// Round-robin dispatcher of queued start requests onto a pool of N worker units.
// Optional per-unit watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module unit_dispatcher #(
  parameter int unsigned N       = 13,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic            MHz10,
  input  logic            nrst,
  unit_dispatcher_if.slave bus
);
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW   = $clog2(QDEPTH + 1);

  logic            en;
  logic [N-1:0]    done;
  logic [N-1:0]    start_q;
  logic [N-1:0]    busy_q;
  logic [N-1:0]    busy_d;
  logic [PW-1:0]   pend_q;
  logic [PW-1:0]   pend_d;
  logic            ovf_q;
  logic [PtrW-1:0] rr_q;
  logic [PtrW-1:0] sel;
  logic            found;
  logic            accept;
  logic            drop;
  logic            dispatch;
  logic [N-1:0]    sel_oh;
  logic [N-1:0]    release_v;
  logic [N-1:0]    expire;
  int unsigned     idx;

  assign en   = bus.en;
  assign done = bus.done;

  // First free unit at or after rr_q, wrapping at N-1; uses registered busy only.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && !busy_q[PtrW'(idx)]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    accept    = en && bus.req && (pend_q < PW'(QDEPTH));
    drop      = en && bus.req && (pend_q == PW'(QDEPTH));
    dispatch  = en && (pend_q != '0) && found;
    sel_oh    = dispatch ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
    release_v = en ? (done & busy_q) : '0;
    busy_d    = (busy_q & ~release_v & ~expire) | sel_oh;
    pend_d    = pend_q;
    if (accept && !dispatch)      pend_d = pend_q + 1'b1;
    else if (!accept && dispatch) pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge MHz10) begin
    if (!nrst) begin
      start_q <= '0;
      busy_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      rr_q    <= '0;
    end else begin
      start_q <= sel_oh;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= drop;
      if (dispatch) rr_q <= (sel == PtrW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q [N];
  logic [N-1:0]    err_q;

  // The counter reaching TIMEOUT this cycle reclaims the unit; a same-cycle done wins.
  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < N; i++) begin
      expire[i] = en && busy_q[i] && !done[i] && (cnt_q[i] == CntW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge MHz10) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      err_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel_oh[i]) begin
          cnt_q[i] <= '0;
        end else if (en && busy_q[i]) begin
          if (done[i] || expire[i]) cnt_q[i] <= '0;
          else                      cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      err_q <= err_q | expire;
    end
  end

  assign bus.timeout_err = err_q;
`else
  logic unused_timeout;

  assign expire          = '0;
  assign bus.timeout_err = '0;
  assign unused_timeout  = ^TIMEOUT;
`endif

  assign bus.start_out  = start_q;
  assign bus.busy       = busy_q;
  assign bus.pending    = pend_q;
  assign bus.overflow   = ovf_q;
  assign bus.queue_full = (pend_q == PW'(QDEPTH));
  assign bus.idle       = (pend_q == '0) && (busy_q == '0);
endmodule

// File: tb/tb_unit_dispatcher.sv
// Self-checking bench for unit_dispatcher: cycle-by-cycle vector table plus watchdog sequences.
module tb_unit_dispatcher;
  localparam int unsigned N       = 13;
  localparam int unsigned QDEPTH  = 4;
  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        req;
    logic [12:0] done;
    logic [12:0] s;
    logic [12:0] b;
    logic [2:0]  p;
    logic        o;
    logic        qf;
    logic        idl;
  } vec_t;

  logic MHz10;
  logic nrst;
  int   tests;
  int   fails;
  vec_t vecs[$];

  unit_dispatcher_if #(.N(N), .QDEPTH(QDEPTH)) bus ();

  unit_dispatcher #(.N(N), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .MHz10 (MHz10),
    .nrst  (nrst),
    .bus   (bus.slave)
  );

  initial MHz10 = 1'b0;
  always #50 MHz10 = ~MHz10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst_n, input logic en, input logic req, input logic [12:0] done,
                     input logic [12:0] s, input logic [12:0] b, input logic [2:0] p,
                     input logic o, input logic qf, input logic idl);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.req = req; v.done = done;
    v.s = s; v.b = b; v.p = p; v.o = o; v.qf = qf; v.idl = idl;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge MHz10);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nrst = 1'b0;
    bus.en = 1'b0;
    bus.req = 1'b0;
    bus.done = '0;
    step();
    step();
    chk("reset start_out", 32'(bus.start_out), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset pending", 32'(bus.pending), 0);
    chk("reset overflow", 32'(bus.overflow), 0);
    chk("reset queue_full", 32'(bus.queue_full), 0);
    chk("reset idle", 32'(bus.idle), 1);
    chk("reset timeout_err", 32'(bus.timeout_err), 0);

`ifndef DISPATCH_TIMEOUT_EN
    // Latency from an idle pool, then a reset while a request is queued.
    add(1, 1, 1, 13'h0,    13'h0,    13'h0,    1, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0001, 13'h0001, 0, 0, 0, 0);
    add(1, 1, 1, 13'h0,    13'h0,    13'h0001, 1, 0, 0, 0);
    add(0, 1, 0, 13'h0,    13'h0,    13'h0,    0, 0, 0, 1);
    // Thirteen back-to-back requests walk the pool, fourteenth stays queued.
    add(1, 1, 1, 13'h0,    13'h0,    13'h0,    1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      add(1, 1, 1, 13'h0, 13'(1 << k), 13'((1 << (k + 1)) - 1), 1, 0, 0, 0);
    end
    add(1, 1, 1, 13'h0,    13'h1000, 13'h1FFF, 1, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0,    13'h1FFF, 1, 0, 0, 0);
    // Release unit 5 and re-dispatch to it.
    add(1, 1, 0, 13'h0020, 13'h0,    13'h1FDF, 1, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0020, 13'h1FFF, 0, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0,    13'h1FFF, 0, 0, 0, 0);
    // Fill the queue, then drop one request.
    for (int q = 1; q <= 4; q++) begin
      add(1, 1, 1, 13'h0, 13'h0, 13'h1FFF, 3'(q), 0, (q == 4), 0);
    end
    add(1, 1, 1, 13'h0,    13'h0,    13'h1FFF, 4, 1, 1, 0);
    add(1, 1, 0, 13'h0,    13'h0,    13'h1FFF, 4, 0, 1, 0);
    // en low freezes everything, including done and overflow.
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 1, 13'h0001, 13'h0, 13'h1FFF, 4, 0, 1, 0);
    end
    add(1, 1, 0, 13'h0001, 13'h0,    13'h1FFE, 4, 0, 1, 0);
    add(1, 1, 0, 13'h0,    13'h0001, 13'h1FFF, 3, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0,    13'h1FFF, 3, 0, 0, 0);
    // Done and dispatch decision in the same cycle: the freed unit waits one cycle.
    add(1, 1, 0, 13'h0002, 13'h0,    13'h1FFD, 3, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0002, 13'h1FFF, 2, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0,    13'h1FFF, 2, 0, 0, 0);
    add(1, 1, 0, 13'h1FFF, 13'h0,    13'h0,    2, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0004, 13'h0004, 1, 0, 0, 0);
    add(1, 1, 0, 13'h0,    13'h0008, 13'h000C, 0, 0, 0, 0);
    add(1, 1, 0, 13'h0020, 13'h0,    13'h000C, 0, 0, 0, 0);
    add(1, 1, 0, 13'h000C, 13'h0,    13'h0,    0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      nrst = vecs[i].rst_n;
      bus.en = vecs[i].en;
      bus.req = vecs[i].req;
      bus.done = vecs[i].done;
      step();
      chk($sformatf("row%0d start_out", i), 32'(bus.start_out), 32'(vecs[i].s));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].b));
      chk($sformatf("row%0d pending", i), 32'(bus.pending), 32'(vecs[i].p));
      chk($sformatf("row%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].o));
      chk($sformatf("row%0d queue_full", i), 32'(bus.queue_full), 32'(vecs[i].qf));
      chk($sformatf("row%0d idle", i), 32'(bus.idle), 32'(vecs[i].idl));
      chk($sformatf("row%0d timeout_err", i), 32'(bus.timeout_err), 0);
    end
    bus.done = '0;
`else
    // Watchdog reclaims unit 0 after TIMEOUT enabled busy cycles.
    nrst = 1'b1;
    bus.en = 1'b1;
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    chk("wd dispatch u0", 32'(bus.start_out), 32'h0001);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk($sformatf("wd u0 still busy c%0d", k), 32'(bus.busy), 32'h0001);
    end
    step();
    chk("wd u0 reclaimed", 32'(bus.busy), 0);
    chk("wd u0 err", 32'(bus.timeout_err), 32'h0001);
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    chk("wd next dispatch u1", 32'(bus.start_out), 32'h0002);
    // Done on the expiry cycle wins over the watchdog.
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk($sformatf("wd u1 busy c%0d", k), 32'(bus.busy), 32'h0002);
    end
    bus.done = 13'h0002;
    step();
    bus.done = '0;
    chk("wd done wins busy", 32'(bus.busy), 0);
    chk("wd done wins err", 32'(bus.timeout_err), 32'h0001);
    step();
    chk("wd err sticky", 32'(bus.timeout_err), 32'h0001);
    nrst = 1'b0;
    step();
    chk("wd err cleared by reset", 32'(bus.timeout_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
